fm_stream_tx: RTL

//  Frame transmitter for the layer line-buffer input stream. Takes FM_DEPTH-channel pixels from an upstream

---
 rtl/fm_stream_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fm_stream_tx.sv
// fm_stream_tx
// Frame transmitter feeding the next layer's window generator. Pixels arrive
// from an upstream valid/ready source, pass through a small FIFO and leave as
// one frame: a verticle_sync pulse followed by FM_WIDTH*FM_WIDTH row-major
// beats, each at least PIX_GAP cycles after the previous one.
//
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous reset, active-high
//   mode_in        1 = calculate, 0 = parameter load (abort / hold idle)
//   start          1-cycle pulse, begins a frame when idle and mode_in=1
//   pix_in         upstream pixel, FM_DEPTH x 16-bit signed
//   pix_in_valid   upstream pixel present
//   pix_in_ready   pixel accepted this cycle when valid
//   verticle_sync  1-cycle start-of-frame pulse
//   data_out_valid 1-cycle beat strobe
//   data_out       pixel of the current beat, held between beats
//   busy           high from accepted start until frame_done
//   frame_done     1-cycle pulse, the cycle after the last beat
//
// state    | meaning
// S_IDLE   | waiting for start with mode_in=1
// S_VS     | verticle_sync cycle, counters freshly cleared, accepting pixels
// S_STREAM | accepting pixels and emitting beats
// S_DONE   | frame_done cycle
module fm_stream_tx #(
    parameter int FM_DEPTH   = 64,
    parameter int FM_WIDTH   = 56,
    parameter int PIX_GAP    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_in,
    input  logic                     start,
    input  logic [16*FM_DEPTH-1:0]   pix_in,
    input  logic                     pix_in_valid,
    output logic                     pix_in_ready,
    output logic                     verticle_sync,
    output logic                     data_out_valid,
    output logic [16*FM_DEPTH-1:0]   data_out,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int PW   = 16 * FM_DEPTH;
    localparam int NPIX = FM_WIDTH * FM_WIDTH;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW   = $clog2(FIFO_DEPTH + 1);
    localparam int GW   = $clog2(PIX_GAP + 1);

    localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
    localparam logic [OW-1:0] FULL_C   = OW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(PIX_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VS,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] fifo_cnt;
    logic [CW-1:0] acc_cnt, emit_cnt;
    logic [GW-1:0] gap_cnt;

    logic fifo_full, fifo_empty;
    logic push, pop, frame_start;

    // Ready depends only on registered state, so a pop in the same cycle
    // never opens the FIFO for a push (no ready->pop combinational path).
    always_comb begin
        fifo_full    = (fifo_cnt == FULL_C);
        fifo_empty   = (fifo_cnt == '0);
        pix_in_ready = ((state == S_VS) || (state == S_STREAM)) && !fifo_full
                       && (acc_cnt < NPIX_C);
        push         = pix_in_valid && pix_in_ready;
        pop          = (state == S_STREAM) && mode_in && !fifo_empty
                       && (gap_cnt == '0) && (emit_cnt < NPIX_C);
        frame_start  = (state == S_IDLE) && start && mode_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        verticle_sync = 1'b0;
        busy          = 1'b0;
        frame_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_VS;
            end
            S_VS: begin
                verticle_sync = 1'b1;
                busy          = 1'b1;
                state_nxt     = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                // Last beat was issued on the previous edge; FIFO is empty.
                if (emit_cnt == NPIX_C) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!mode_in) state_nxt = S_IDLE;
    end

    // Pixel storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            acc_cnt        <= '0;
            emit_cnt       <= '0;
            gap_cnt        <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else if (!mode_in) begin
            // Abort: flush and clear, but keep the last pixel on data_out.
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            acc_cnt        <= '0;
            emit_cnt       <= '0;
            gap_cnt        <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= pop;
            if (pop) data_out <= fifo_mem[rd_ptr];

            if (frame_start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                acc_cnt  <= '0;
                emit_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    emit_cnt <= emit_cnt + 1'b1;
                end
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end

            if (pop) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule
